// File: rtl/mem_responder.sv
// CPU-side program/data store: 1-cycle registered reads, one write per mem_wr strobe, ready/valid program loader.
// Optional MEM_PARITY_EN adds a per-word even-parity bit and a par_err output that also feeds prot_err.
module mem_responder #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  input  logic          mem_rd,
  input  logic          mem_wr,
  output logic [DW-1:0] data_out,
  output logic          rd_valid,
  input  logic          ld_en,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
`ifdef MEM_PARITY_EN
  output logic          par_err,
`endif
  output logic          prot_err
);

  localparam int DEPTH = 2**AW;
`ifdef MEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic [1:0] {IDLE, RD_ACTIVE, WR_DONE, LOAD} state_t;

  state_t        state, state_nxt;
  logic          rd_valid_nxt;
  logic          ld_ready_nxt;
  logic          prot_set;
  logic          rd_load;
  logic          cpu_we;
  logic          ld_we;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rd_word;

  assign rd_word = mem[addr];

  function automatic logic [MW-1:0] enc(input logic [DW-1:0] d);
`ifdef MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  always_comb begin
    state_nxt    = state;
    rd_valid_nxt = 1'b0;
    ld_ready_nxt = 1'b0;
    prot_set     = 1'b0;
    rd_load      = 1'b0;
    cpu_we       = 1'b0;
    ld_we        = 1'b0;
    case (state)
      IDLE: begin
        if (ld_en) begin
          state_nxt    = LOAD;
          ld_ready_nxt = 1'b1;
        end else if (mem_rd && mem_wr) begin
          prot_set = 1'b1;
        end else if (mem_wr) begin
          cpu_we    = 1'b1;
          state_nxt = WR_DONE;
        end else if (mem_rd) begin
          rd_load      = 1'b1;
          rd_valid_nxt = 1'b1;
          state_nxt    = RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        // A write strobe during a read aborts the read without writing.
        if (mem_wr) begin
          prot_set  = 1'b1;
          state_nxt = IDLE;
        end else if (mem_rd) begin
          rd_load      = 1'b1;
          rd_valid_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      WR_DONE: begin
        prot_set = mem_rd;
        if (!mem_wr) state_nxt = IDLE;
      end
      LOAD: begin
        prot_set = mem_rd | mem_wr;
        if (ld_en) begin
          ld_ready_nxt = 1'b1;
          ld_we        = ld_valid & ld_ready;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      data_out <= '0;
      rd_valid <= 1'b0;
      ld_ready <= 1'b0;
      prot_err <= 1'b0;
`ifdef MEM_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      rd_valid <= rd_valid_nxt;
      ld_ready <= ld_ready_nxt;
      if (rd_load) data_out <= rd_word[DW-1:0];
`ifdef MEM_PARITY_EN
      if (rd_load) par_err <= ^rd_word;
      prot_err <= prot_err | prot_set | (rd_load & (^rd_word));
`else
      prot_err <= prot_err | prot_set;
`endif
    end
  end

  // Storage is intentionally not reset so a loaded program survives a CPU reset.
  always_ff @(posedge clk) begin
    if (cpu_we)
      mem[addr] <= enc(data_in);
    else if (ld_we)
      mem[ld_addr] <= enc(ld_data);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: expected read data is queued at issue and checked by a monitor.
module tb_mem_responder;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          ld_en, ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          prot_err;
`ifdef MEM_PARITY_EN
  logic          par_err;
`endif

  mem_responder #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_(rst_), .addr(addr), .data_in(data_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .data_out(data_out), .rd_valid(rd_valid),
    .ld_en(ld_en), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef MEM_PARITY_EN
    .par_err(par_err),
`endif
    .prot_err(prot_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] words [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every cycle with rd_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_ === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got data %0h expected no read", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", {24'h0, data_out}, {24'h0, mon_exp});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse;
    rst_ = 1'b0;
    #2;
    rst_ = 1'b1;
  endtask

  // Read burst of n cycles; fixed_a < 0 picks a fresh random address every cycle.
  task automatic rd_burst(input int n, input int fixed_a);
    logic [DW-1:0] last;
    last = '0;
    for (int i = 0; i < n; i++) begin
      addr   = (fixed_a < 0) ? AW'($urandom) : AW'(fixed_a);
      mem_rd = 1'b1;
      last   = model[addr];
      exp_q.push_back(last);
      tick();
    end
    mem_rd = 1'b0;
    addr   = AW'($urandom);
    tick();
    check("rd_end_valid", {31'h0, rd_valid}, 32'h0);
    check("rd_end_hold", {24'h0, data_out}, {24'h0, last});
  endtask

  // Write strobe held n cycles; data_in changes to d2 after the first edge.
  task automatic wr_burst(input int a, input logic [DW-1:0] d, input logic [DW-1:0] d2, input int n);
    addr    = AW'(a);
    data_in = d;
    mem_wr  = 1'b1;
    model[a] = d;
    for (int i = 0; i < n; i++) begin
      tick();
      data_in = d2;
    end
    mem_wr = 1'b0;
    tick();
  endtask

  task automatic load_all;
    int idx, budget, first_hs, fourth_hs;
    bit hs;
    idx = 0; budget = 0; first_hs = -1; fourth_hs = -1;
    ld_en = 1'b1;
    while (idx < DEPTH && budget < 400) begin
      ld_valid = (idx < 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ld_addr  = AW'(idx);
      ld_data  = words[idx];
      hs = ld_valid && ld_ready;
      tick();
      budget++;
      if (hs) begin
        model[idx] = words[idx];
        if (idx == 0) first_hs = budget;
        if (idx == 3) fourth_hs = budget;
        idx++;
      end
    end
    check("ld_all_words", idx, DEPTH);
    check("ld_back_to_back", fourth_hs - first_hs, 3);
    // Word presented on the edge ld_en falls must be dropped.
    ld_en    = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = AW'(4);
    ld_data  = ~model[4];
    tick();
    ld_valid = 1'b0;
    check("ld_ready_drop", {31'h0, ld_ready}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    rst_ = 1'b0; addr = '0; data_in = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    ld_en = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < DEPTH; i++) words[i] = DW'($urandom);
    words[0] = 8'hA0; words[1] = 8'h41; words[2] = 8'h5C; words[3] = 8'hE7;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", {24'h0, data_out}, 32'h0);
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
    check("rst_prot_err", {31'h0, prot_err}, 32'h0);
    rst_ = 1'b1;
    tick();

    load_all();

    // Directed read: addr 2 then 3.
    addr = AW'(2); mem_rd = 1'b1; exp_q.push_back(model[2]); tick();
    check("rd_addr2", {24'h0, data_out}, 32'h5C);
    addr = AW'(3); exp_q.push_back(model[3]); tick();
    check("rd_addr3", {24'h0, data_out}, 32'hE7);
    mem_rd = 1'b0; tick();
    check("rd_drop_valid", {31'h0, rd_valid}, 32'h0);
    check("rd_drop_hold", {24'h0, data_out}, 32'hE7);

    // One write per strobe, first data wins; dropped loader word left addr 4 alone.
    wr_burst(5, 8'h3C, 8'hFF, 3);
    rd_burst(1, 5);
    check("wr_once_addr5", {24'h0, data_out}, 32'h3C);
    rd_burst(1, 4);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        rd_burst($urandom_range(1, 4), -1);
      else
        wr_burst($urandom_range(8, DEPTH - 1), DW'($urandom), DW'($urandom), $urandom_range(1, 3));
    end
    check("prot_clean", {31'h0, prot_err}, 32'h0);

    // Write strobe during an active read: abort, no write, sticky error.
    addr = AW'(6); mem_rd = 1'b1; exp_q.push_back(model[6]); tick();
    mem_wr = 1'b1; data_in = ~model[6]; tick();
    check("rdwr_abort_valid", {31'h0, rd_valid}, 32'h0);
    check("rdwr_prot", {31'h0, prot_err}, 32'h1);
    mem_rd = 1'b0; mem_wr = 1'b0; tick();
    rd_burst(1, 6);

    // Contents survive reset; simultaneous strobes in IDLE set prot_err only.
    rst_pulse();
    check("rst2_prot", {31'h0, prot_err}, 32'h0);
    tick();
    addr = AW'(1); data_in = 8'h00; mem_rd = 1'b1; mem_wr = 1'b1; tick();
    mem_rd = 1'b0; mem_wr = 1'b0;
    check("idle_both_prot", {31'h0, prot_err}, 32'h1);
    check("idle_both_valid", {31'h0, rd_valid}, 32'h0);
    tick();
    rd_burst(1, 1);
    check("mem1_kept", {24'h0, data_out}, 32'h41);
    repeat (3) tick();
    check("prot_sticky", {31'h0, prot_err}, 32'h1);

    // Asynchronous reset in the middle of a read.
    rst_pulse();
    tick();
    addr = AW'(3); mem_rd = 1'b1; exp_q.push_back(model[3]); tick();
    @(negedge clk);
    #2;
    rst_ = 1'b0;
    #1;
    check("async_data_out", {24'h0, data_out}, 32'h0);
    check("async_rd_valid", {31'h0, rd_valid}, 32'h0);
    mem_rd = 1'b0;
    #1;
    rst_ = 1'b1;
    tick();

    // Read strobe during WR_DONE.
    check("pre_wrdone_prot", {31'h0, prot_err}, 32'h0);
    addr = AW'(9); data_in = 8'h77; mem_wr = 1'b1; model[9] = 8'h77; tick();
    mem_rd = 1'b1; data_in = 8'h11; tick();
    mem_rd = 1'b0; mem_wr = 1'b0; tick();
    check("wrdone_prot", {31'h0, prot_err}, 32'h1);
    rd_burst(1, 9);

    // CPU strobe while loading.
    rst_pulse();
    tick();
    ld_en = 1'b1; tick();
    addr = AW'(10); data_in = ~model[10]; mem_wr = 1'b1; tick();
    mem_wr = 1'b0; ld_en = 1'b0; tick();
    check("load_strobe_prot", {31'h0, prot_err}, 32'h1);
    tick();
    rd_burst(1, 10);

`ifdef MEM_PARITY_EN
    rst_pulse();
    tick();
    dut.mem[0][DW] = ~dut.mem[0][DW];
    rd_burst(1, 0);
    check("par_data", {24'h0, data_out}, 32'hA0);
    check("par_err", {31'h0, par_err}, 32'h1);
    check("par_prot", {31'h0, prot_err}, 32'h1);
`endif

    repeat (2) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
